// File: rtl/irq_controller.sv
// irq_controller: prioritised edge/level interrupt controller with memory-mapped pending/enable/ctrl registers
module irq_controller #(
    parameter int                 NUM_SRC   = 8,
    parameter int                 VEC_W     = 4,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b1}},
    parameter logic [63:0]        ADDR_BASE = 64'h8000_0020
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [63:0]        bus_address,
    input  logic [63:0]        bus_write_data,
    input  logic               bus_write_enable,
    input  logic               bus_read_enable,
    output logic [63:0]        bus_read_data,
    output logic               bus_selected,
    output logic [VEC_W-1:0]   interrupt_vector,
    input  logic               interrupt_done
);
    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_e;

    state_e             state_q;
    logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q, pending_q, enable_q;
    logic [NUM_SRC-1:0] pending_d, enable_d, rise, w1c, done_clr;
    logic               gie_q, gie_d, wr;
    logic [VEC_W-1:0]   vector_q, insvc_q, cand_idx;
    logic               cand_vld;
    logic [63:0]        off;
    logic               unused_bits;

    assign off              = bus_address - ADDR_BASE;
    assign unused_bits      = ^{off[63:4], bus_write_data[63:NUM_SRC]};
    assign interrupt_vector = vector_q;

    always_comb begin
        bus_selected = (bus_address >= ADDR_BASE) && (bus_address < ADDR_BASE + 64'd16);
        wr           = bus_write_enable && bus_selected;
        rise         = sync2_q & ~prev_q;
        w1c          = (wr && off[3:0] == 4'h0) ? bus_write_data[NUM_SRC-1:0] : '0;
        done_clr     = (state_q == ACTIVE && interrupt_done) ? (NUM_SRC'(1) << insvc_q) : '0;
        // a fresh edge beats any clear landing in the same cycle
        pending_d    = (((pending_q & ~(w1c | done_clr)) | rise) & EDGE_MASK) | (sync2_q & ~EDGE_MASK);
        enable_d     = (wr && off[3:0] == 4'h4) ? bus_write_data[NUM_SRC-1:0] : enable_q;
        gie_d        = (wr && off[3:0] == 4'h8) ? bus_write_data[0] : gie_q;
        bus_read_data = !(bus_selected && bus_read_enable) ? 64'd0 :
                        off[3:0] == 4'h0 ? 64'(pending_q) :
                        off[3:0] == 4'h4 ? 64'(enable_q) :
                        off[3:0] == 4'h8 ? 64'(gie_q) :
                        off[3:0] == 4'hC ? 64'(vector_q) : 64'd0;
    end

    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending_q[i] && enable_q[i]) begin
                cand_vld = 1'b1;
                cand_idx = VEC_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            enable_q  <= '1;
            gie_q     <= 1'b1;
        end else begin
            sync1_q   <= irq_src;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            gie_q     <= gie_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            vector_q <= '0;
            insvc_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (gie_q && cand_vld) begin
                    vector_q <= cand_idx + 1'b1;
                    insvc_q  <= cand_idx;
                    state_q  <= ACTIVE;
                end
                ACTIVE: if (interrupt_done) begin
                    vector_q <= '0;
                    state_q  <= GAP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
